edge_event_unit: RTL

Multi-channel successor to the single-bit edge detector. It synchronises `CH` asynchronous inputs through a configurable flop chain, deglitches each one with a programmable stability filter, and detects rise, fall or both edges per channel under a run-time mode. Detected events are latched in sticky write-1-to-clear status bits that drive one interrupt line. It sits between raw pins or foreign-clock signals and the register/interrupt fabric.

---
 rtl/edge_evt_pkg.sv | 18 +
 rtl/edge_evt_chan.sv | 62 ++++++
 rtl/edge_event_unit.sv | 72 +++++++
 3 files changed

// File: rtl/edge_evt_pkg.sv
// Shared definitions for the edge event unit: per-channel mode encoding and
// the mode/edge match helper.
package edge_evt_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_OFF  = 2'b00;
  localparam mode_t MODE_RISE = 2'b01;
  localparam mode_t MODE_FALL = 2'b10;
  localparam mode_t MODE_BOTH = 2'b11;

  // new_level is the accepted filtered value: 1 means a rise, 0 a fall.
  function automatic logic edge_match(input mode_t mode, input logic new_level);
    if (new_level) return (mode == MODE_RISE) || (mode == MODE_BOTH);
    else           return (mode == MODE_FALL) || (mode == MODE_BOTH);
  endfunction

endpackage

// File: rtl/edge_evt_chan.sv
// One channel of the edge event unit: synchroniser, stability filter and
// mode-qualified edge detector.
module edge_evt_chan
  import edge_evt_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  mode_t             mode,
  input  logic [FILT_W-1:0] filt_len,
  output logic              level,
  output logic              evt_pulse
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   filt_q, filt_d;
  logic [FILT_W-1:0]      cnt_q, cnt_d;
  logic                   evt_q, evt_d;
  logic                   s;
  logic                   update;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    s      = sync_q[SYNC_STAGES-1];
    filt_d = filt_q;
    cnt_d  = '0;
    update = 1'b0;
    if (s != filt_q) begin
      // >= so a shortened filt_len takes effect on the next mismatching cycle.
      if (cnt_q >= filt_len) begin
        update = 1'b1;
        filt_d = s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    evt_d = update && edge_match(mode, s);
  end

  // NOTE: state updates use non-blocking assignments; reset is synchronous.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
      evt_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
      evt_q  <= evt_d;
    end
  end

  assign level     = filt_q;
  assign evt_pulse = evt_q;

endmodule

// File: rtl/edge_event_unit.sv
// Multi-channel edge event unit: per-channel sync/filter/edge detect feeding
// sticky W1C status and one interrupt. Define EDGE_EVT_OVERRUN_EN for the ovr flags.
module edge_event_unit
  import edge_evt_pkg::*;
#(
  parameter int CH          = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH-1:0]     din,
  input  logic [2*CH-1:0]   mode,
  input  logic [FILT_W-1:0] filt_len,
  input  logic [CH-1:0]     irq_en,
  input  logic [CH-1:0]     clr,
  output logic [CH-1:0]     level,
  output logic [CH-1:0]     evt_pulse,
  output logic [CH-1:0]     status,
  output logic              irq
`ifdef EDGE_EVT_OVERRUN_EN
  ,
  output logic [CH-1:0]     ovr
`endif
);

  for (genvar i = 0; i < CH; i++) begin : g_chan
    edge_evt_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_W     (FILT_W)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .din      (din[i]),
      .mode     (mode_t'(mode[2*i +: 2])),
      .filt_len (filt_len),
      .level    (level[i]),
      .evt_pulse(evt_pulse[i])
    );
  end

  logic [CH-1:0] status_q, status_d;

  // A new event and a clear in the same cycle leave the flag set.
  always_comb begin
    status_d = (status_q & ~clr) | evt_pulse;
  end

  always_ff @(posedge clk) begin
    if (rst) status_q <= '0;
    else     status_q <= status_d;
  end

  assign status = status_q;
  assign irq    = |(status_q & irq_en);

`ifdef EDGE_EVT_OVERRUN_EN
  logic [CH-1:0] ovr_q, ovr_d;

  always_comb begin
    ovr_d = (ovr_q & ~clr) | (evt_pulse & status_q & ~clr);
  end

  always_ff @(posedge clk) begin
    if (rst) ovr_q <= '0;
    else     ovr_q <= ovr_d;
  end

  assign ovr = ovr_q;
`endif

endmodule
